// File: rtl/discrete_mixer_pkg.sv
// Shared types and constants for the discrete audio mixer: FSM state,
// Q1.15 shift and accumulator sizing.
package discrete_mixer_pkg;

  typedef enum logic [1:0] {IDLE, MAC, DONE} state_t;

  localparam int Q_SHIFT = 15;

  // Full-precision products plus one bit per channel doubling plus sign headroom.
  function automatic int acc_width(input int num_ch);
    return 32 + $clog2(num_ch) + 1;
  endfunction

endpackage

// File: rtl/mixer_clip.sv
// Rescales the Q1.15 accumulator to a 16-bit sample.
// MIXER_SATURATE_EN selects clamping; otherwise the low 16 bits wrap.
module mixer_clip
  import discrete_mixer_pkg::*;
#(
  parameter int ACC_W = 35
) (
  input  logic signed [ACC_W-1:0] i_acc,
  output logic        [15:0]      o_out
);

  logic signed [ACC_W-1:0] w_sh;
  logic                    w_unused;

  assign w_sh = i_acc >>> Q_SHIFT;

`ifdef MIXER_SATURATE_EN
  localparam logic signed [ACC_W-1:0] MAXV = ACC_W'(32767);
  localparam logic signed [ACC_W-1:0] MINV = -ACC_W'(32768);

  assign w_unused = ^i_acc[Q_SHIFT-1:0];

  always_comb begin
    o_out = w_sh[15:0];
    if (w_sh > MAXV)      o_out = 16'h7FFF;
    else if (w_sh < MINV) o_out = 16'h8000;
  end
`else
  assign w_unused = ^{w_sh[ACC_W-1:16], i_acc[Q_SHIFT-1:0]};
  assign o_out    = w_sh[15:0];
`endif

endmodule

// File: rtl/discrete_audio_mixer.sv
// Time-multiplexed weighted mixer: snapshot on audio_clk_en, one MAC per clk
// through a single shared multiplier, then rescale/clip (see MIXER_SATURATE_EN).
module discrete_audio_mixer
  import discrete_mixer_pkg::*;
#(
  parameter int NUM_CH = 4
) (
  input  logic                   clk,
  input  logic                   I_RSTn,
  input  logic                   audio_clk_en,
  input  logic [NUM_CH*16-1:0]   in,
  input  logic [NUM_CH*16-1:0]   gain,
  output logic [15:0]            out,
  output logic                   out_valid,
  output logic                   overrun
);

  localparam int ACC_W = acc_width(NUM_CH);
  localparam int CH_W  = $clog2(NUM_CH);

  state_t                         r_state;
  logic [NUM_CH-1:0][15:0]        r_snap_in, r_snap_gain;
  logic signed [ACC_W-1:0]        r_acc;
  logic [CH_W-1:0]                r_ch;

  logic signed [15:0]             w_a, w_b;
  logic signed [31:0]             w_prod;
  logic signed [ACC_W-1:0]        w_prod_ext;
  logic [15:0]                    w_clip;

  // Single multiplier fed by the channel-indexed snapshot mux.
  assign w_a        = r_snap_in[r_ch];
  assign w_b        = r_snap_gain[r_ch];
  assign w_prod     = w_a * w_b;
  assign w_prod_ext = {{(ACC_W-32){w_prod[31]}}, w_prod};

  mixer_clip #(.ACC_W(ACC_W)) u_clip (
    .i_acc (r_acc),
    .o_out (w_clip)
  );

  always_ff @(posedge clk or negedge I_RSTn) begin
    if (!I_RSTn) begin
      r_state     <= IDLE;
      r_snap_in   <= '0;
      r_snap_gain <= '0;
      r_acc       <= '0;
      r_ch        <= '0;
      out         <= '0;
      out_valid   <= 1'b0;
      overrun     <= 1'b0;
    end else begin
      out_valid <= 1'b0;
      // Any strobe outside IDLE (including the DONE->IDLE cycle) is dropped.
      if (audio_clk_en && r_state != IDLE) overrun <= 1'b1;
      case (r_state)
        IDLE: if (audio_clk_en) begin
          r_snap_in   <= in;
          r_snap_gain <= gain;
          r_acc       <= '0;
          r_ch        <= '0;
          r_state     <= MAC;
        end
        MAC: begin
          r_acc <= r_acc + w_prod_ext;
          r_ch  <= r_ch + 1'b1;
          if (r_ch == CH_W'(NUM_CH-1)) r_state <= DONE;
        end
        DONE: begin
          out       <= w_clip;
          out_valid <= 1'b1;
          r_state   <= IDLE;
        end
        default: r_state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_discrete_audio_mixer.sv
// Directed table-driven bench for discrete_audio_mixer (NUM_CH=4), plus
// sequences for overrun, strobe-in-DONE and reset mid-mix.
module tb_discrete_audio_mixer;

  localparam int NUM_CH = 4;
  localparam int LAT    = NUM_CH + 1;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        strobe;
  logic [63:0] din, g;
  logic [15:0] out;
  logic        out_valid, overrun;

  int n_vec = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  discrete_audio_mixer #(.NUM_CH(NUM_CH)) dut (
    .clk          (clk),
    .I_RSTn       (rst_n),
    .audio_clk_en (strobe),
    .in           (din),
    .gain         (g),
    .out          (out),
    .out_valid    (out_valid),
    .overrun      (overrun)
  );

  typedef struct {
    logic [63:0] din;
    logic [63:0] g;
    logic [15:0] exp;
    string       nm;
  } vec_t;

  function automatic logic [63:0] pk(input int a0, input int a1, input int a2, input int a3);
    return {a3[15:0], a2[15:0], a1[15:0], a0[15:0]};
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, exp);
    end
  endtask

  // Strobe once, wait (bounded) for out_valid, check latency, value and pulse width.
  task automatic run_vec(input vec_t v);
    int cyc;
    @(negedge clk);
    din = v.din; g = v.g; strobe = 1'b1;
    @(negedge clk);
    strobe = 1'b0;
    cyc = 0;
    while (!out_valid && cyc < 20) begin
      @(negedge clk);
      cyc++;
    end
    chk({v.nm, " latency"}, cyc, LAT);
    chk({v.nm, " out"}, {16'h0, out}, {16'h0, v.exp});
    @(negedge clk);
    chk({v.nm, " pulse width"}, {31'h0, out_valid}, 32'h0);
    chk({v.nm, " out hold"}, {16'h0, out}, {16'h0, v.exp});
  endtask

  vec_t vt[6];

  initial begin
    int   pulses, pcyc;
    logic [15:0] pval;

    vt[0] = '{pk(16384, 0, 0, 0), pk(32'h7FFF, 0, 0, 0), 16'd16383, "unity"};
    vt[1] = '{pk(1000, -2000, 0, 0), pk(32'h4000, 32'h4000, 0, 0), 16'hFE0C, "mixed signs"};
`ifdef MIXER_SATURATE_EN
    vt[2] = '{pk(32767, 32767, 32767, 32767), pk(32'h7FFF, 32'h7FFF, 32'h7FFF, 32'h7FFF), 16'h7FFF, "full scale"};
    vt[3] = '{pk(-32768, 0, 0, 0), pk(32'h8000, 0, 0, 0), 16'h7FFF, "neg1 x neg1"};
`else
    vt[2] = '{pk(32767, 32767, 32767, 32767), pk(32'h7FFF, 32'h7FFF, 32'h7FFF, 32'h7FFF), 16'hFFF8, "full scale"};
    vt[3] = '{pk(-32768, 0, 0, 0), pk(32'h8000, 0, 0, 0), 16'h8000, "neg1 x neg1"};
`endif
    vt[4] = '{pk(-1, 0, 0, 0), pk(32'h4000, 0, 0, 0), 16'hFFFF, "floor trunc"};
    vt[5] = '{pk(0, 0, 0, 20000), pk(0, 0, 0, 32'h8000), 16'hB1E0, "ch3 neg gain"};

    rst_n = 1'b0; strobe = 1'b0; din = '0; g = '0;
    repeat (2) @(negedge clk);
    chk("reset out", {16'h0, out}, 32'h0);
    chk("reset out_valid", {31'h0, out_valid}, 32'h0);
    chk("reset overrun", {31'h0, overrun}, 32'h0);
    rst_n = 1'b1;

    for (int i = 0; i < 6; i++) begin
      run_vec(vt[i]);
      repeat (2) @(negedge clk);
    end
    chk("no overrun after spaced strobes", {31'h0, overrun}, 32'h0);

    // Second strobe at T+2 with ch0 changed: ignored, first snapshot wins.
    @(negedge clk);
    din = vt[0].din; g = vt[0].g; strobe = 1'b1;
    @(negedge clk);
    strobe = 1'b0;
    pulses = 0; pcyc = 0; pval = '0;
    for (int c = 1; c <= 16; c++) begin
      if (c == 2) begin strobe = 1'b1; din = pk(1000, 0, 0, 0); end
      else strobe = 1'b0;
      @(negedge clk);
      if (out_valid) begin pulses++; pcyc = c; pval = out; end
    end
    chk("overrun pulses", pulses, 1);
    chk("overrun latency", pcyc, LAT);
    chk("overrun snapshot out", {16'h0, pval}, 32'd16383);
    chk("overrun sticky", {31'h0, overrun}, 32'h1);

    // Reset while in MAC: aborts, clears everything, no pulse.
    @(negedge clk);
    din = vt[1].din; g = vt[1].g; strobe = 1'b1;
    @(negedge clk);
    strobe = 1'b0;
    @(posedge clk); @(posedge clk);
    #1 rst_n = 1'b0;
    #1;
    chk("midreset out", {16'h0, out}, 32'h0);
    chk("midreset out_valid", {31'h0, out_valid}, 32'h0);
    chk("midreset overrun", {31'h0, overrun}, 32'h0);
    @(negedge clk);
    rst_n = 1'b1;
    pulses = 0;
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      if (out_valid) pulses++;
    end
    chk("midreset no pulse", pulses, 0);
    run_vec(vt[1]);
    chk("post reset overrun", {31'h0, overrun}, 32'h0);

    // Strobe landing on the DONE cycle is busy: ignored and flagged.
    repeat (2) @(negedge clk);
    din = vt[0].din; g = vt[0].g; strobe = 1'b1;
    @(negedge clk);
    strobe = 1'b0;
    pulses = 0; pval = '0;
    for (int c = 1; c <= 16; c++) begin
      strobe = (c == LAT);
      @(negedge clk);
      if (out_valid) begin pulses++; pval = out; end
    end
    chk("done-strobe pulses", pulses, 1);
    chk("done-strobe out", {16'h0, pval}, 32'd16383);
    chk("done-strobe overrun", {31'h0, overrun}, 32'h1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
